// File: rtl/zvc_pkg.sv
// Shared ZVC definitions: default datapath widths and the line-packer FSM states.
package zvc_pkg;

    localparam int unsigned WORD_WIDTH = 8;
    localparam int unsigned LINE_SIZE  = 32;
    localparam int unsigned PSUM_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 6;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } zvc_state_e;

endpackage

// File: rtl/zvc_line_scatter.sv
// Combinational scatter: moves each kept word to slot psum-1, producing a dense run
// starting at slot 0 plus the number of kept words.
module zvc_line_scatter
    import zvc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = zvc_pkg::WORD_WIDTH,
    parameter int unsigned LINE_SIZE  = zvc_pkg::LINE_SIZE,
    parameter int unsigned PSUM_WIDTH = zvc_pkg::PSUM_WIDTH,
    parameter int unsigned CNT_WIDTH  = zvc_pkg::CNT_WIDTH
) (
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] line,
    input  logic [LINE_SIZE-1:0]            mask,
    input  logic [LINE_SIZE*PSUM_WIDTH-1:0] psum,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] compact_c,
    output logic [CNT_WIDTH-1:0]            count_c
);

    // Only the low CNT_WIDTH bits of each prefix entry carry information.
    logic unused_psum;
    assign unused_psum = ^psum;

    // An inclusive prefix at lane i never exceeds i+1, so slot j only looks at lanes i >= j.
    always_comb begin
        compact_c = '0;
        for (int unsigned j = 0; j < LINE_SIZE; j++) begin
            for (int unsigned i = j; i < LINE_SIZE; i++) begin
                if (mask[i] && (psum[i*PSUM_WIDTH +: CNT_WIDTH] == CNT_WIDTH'(j + 1))) begin
                    compact_c[j*WORD_WIDTH +: WORD_WIDTH] =
                        compact_c[j*WORD_WIDTH +: WORD_WIDTH] | line[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    assign count_c = psum[(LINE_SIZE-1)*PSUM_WIDTH +: CNT_WIDTH];

endmodule

// File: rtl/zvc_line_packer.sv
// ZVC line packer: scatters nonzero words of each line (S1) and concatenates the dense
// runs into full packed output lines (S2), with backpressure and end-of-tile flush.
module zvc_line_packer
    import zvc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = zvc_pkg::WORD_WIDTH,
    parameter int unsigned LINE_SIZE  = zvc_pkg::LINE_SIZE,
    parameter int unsigned PSUM_WIDTH = zvc_pkg::PSUM_WIDTH,
    parameter int unsigned CNT_WIDTH  = zvc_pkg::CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] in_line,
    input  logic [LINE_SIZE-1:0]            in_mask,
    input  logic [LINE_SIZE*PSUM_WIDTH-1:0] in_psum,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] out_line,
    output logic [CNT_WIDTH-1:0]            out_count,
    output logic                            out_last
);

    localparam int unsigned LINE_BITS = LINE_SIZE * WORD_WIDTH;
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

    logic [LINE_BITS-1:0]   scat_line_c;
    logic [CNT_WIDTH-1:0]   scat_count_c;

    logic                   s1_valid;
    logic [LINE_BITS-1:0]   s1_line;
    logic [CNT_WIDTH-1:0]   s1_count;
    logic                   s1_last;

    zvc_state_e             state, state_next;
    logic [LINE_BITS-1:0]   acc, acc_next;
    logic [CNT_WIDTH-1:0]   fill, fill_next;

    logic                   out_free_c;
    logic                   s2_advance_c;
    logic                   out_load_c;
    logic [LINE_BITS-1:0]   out_line_next;
    logic [CNT_WIDTH-1:0]   out_count_next;
    logic                   out_last_next;
    logic [2*LINE_BITS-1:0] merged_c;
    logic [SUM_WIDTH-1:0]   total_c;

    zvc_line_scatter #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_SIZE  (LINE_SIZE),
        .PSUM_WIDTH (PSUM_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_scatter (
        .line      (in_line),
        .mask      (in_mask),
        .psum      (in_psum),
        .compact_c (scat_line_c),
        .count_c   (scat_count_c)
    );

    assign out_free_c   = !out_valid || out_ready;
    assign s2_advance_c = s1_valid && out_free_c && (state == ACCUM);
    assign in_ready     = !s1_valid || s2_advance_c;

    // acc slots at and above fill are always zero, so appending is an OR with a shifted run.
    assign merged_c = {{LINE_BITS{1'b0}}, acc}
                    | ({{LINE_BITS{1'b0}}, s1_line} << (fill * WORD_WIDTH));
    assign total_c  = SUM_WIDTH'(fill) + SUM_WIDTH'(s1_count);

    // S1: compact line register
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_line  <= '0;
            s1_count <= '0;
            s1_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_line  <= scat_line_c;
            s1_count <= scat_count_c;
            s1_last  <= in_last;
        end else if (s2_advance_c) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 next-state, accumulator update and output-register load
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        fill_next      = fill;
        out_load_c     = 1'b0;
        out_line_next  = out_line;
        out_count_next = out_count;
        out_last_next  = out_last;
        case (state)
            ACCUM: begin
                if (s2_advance_c) begin
                    if (s1_last && (total_c <= SUM_WIDTH'(LINE_SIZE))) begin
                        out_load_c     = 1'b1;
                        out_line_next  = merged_c[LINE_BITS-1:0];
                        out_count_next = CNT_WIDTH'(total_c);
                        out_last_next  = 1'b1;
                        acc_next       = '0;
                        fill_next      = '0;
                    end else if (total_c >= SUM_WIDTH'(LINE_SIZE)) begin
                        out_load_c     = 1'b1;
                        out_line_next  = merged_c[LINE_BITS-1:0];
                        out_count_next = CNT_WIDTH'(LINE_SIZE);
                        out_last_next  = 1'b0;
                        acc_next       = merged_c[2*LINE_BITS-1:LINE_BITS];
                        fill_next      = CNT_WIDTH'(total_c - SUM_WIDTH'(LINE_SIZE));
                        if (s1_last) begin
                            state_next = FLUSH;
                        end
                    end else begin
                        acc_next  = merged_c[LINE_BITS-1:0];
                        fill_next = CNT_WIDTH'(total_c);
                    end
                end
            end
            FLUSH: begin
                if (out_free_c) begin
                    out_load_c     = 1'b1;
                    out_line_next  = acc;
                    out_count_next = fill;
                    out_last_next  = 1'b1;
                    acc_next       = '0;
                    fill_next      = '0;
                    state_next     = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
            acc   <= '0;
            fill  <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            fill  <= fill_next;
        end
    end

    // Output register: loads when empty or draining in the same cycle, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_line  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else if (out_load_c) begin
            out_valid <= 1'b1;
            out_line  <= out_line_next;
            out_count <= out_count_next;
            out_last  <= out_last_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zvc_line_packer.sv
// Self-checking bench for zvc_line_packer: directed scenarios plus randomized tiles,
// scored against a word-queue reference model.
module tb_zvc_line_packer;

    localparam int unsigned WW = zvc_pkg::WORD_WIDTH;
    localparam int unsigned LS = zvc_pkg::LINE_SIZE;
    localparam int unsigned PW = zvc_pkg::PSUM_WIDTH;
    localparam int unsigned CW = zvc_pkg::CNT_WIDTH;
    localparam int unsigned DW = LS * WW;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_line;
    logic [LS-1:0] in_mask;
    logic [LS*PW-1:0] in_psum;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_line;
    logic [CW-1:0] out_count;
    logic          out_last;

    logic rdy_dir, rdy_rand, rand_rdy;
    assign out_ready = rand_rdy ? rdy_rand : rdy_dir;

    zvc_line_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_line   (in_line),
        .in_mask   (in_mask),
        .in_psum   (in_psum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_line  (out_line),
        .out_count (out_count),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a FIFO of kept words; full lines pop out as soon as 32 are present,
    // and a last line pops everything that remains.
    typedef struct packed {
        logic [DW-1:0] line;
        logic [CW-1:0] count;
        logic          last;
    } exp_t;

    logic [WW-1:0] wq[$];
    exp_t          eq[$];

    function automatic void model_emit(input int n, input logic last);
        exp_t e;
        e.line = '0;
        for (int k = 0; k < n; k++) e.line[k*WW +: WW] = wq.pop_front();
        e.count = CW'(n);
        e.last  = last;
        eq.push_back(e);
    endfunction

    function automatic void model_accept(input logic [DW-1:0] line, input logic [LS-1:0] mask,
                                         input logic last);
        for (int i = 0; i < int'(LS); i++) if (mask[i]) wq.push_back(line[i*WW +: WW]);
        if (!last) begin
            if (wq.size() >= int'(LS)) model_emit(int'(LS), 1'b0);
        end else begin
            if (wq.size() > int'(LS)) model_emit(int'(LS), 1'b0);
            model_emit(wq.size(), 1'b1);
        end
    endfunction

    function automatic logic [LS*PW-1:0] psum_of(input logic [LS-1:0] m);
        logic [LS*PW-1:0] r;
        int s;
        s = 0;
        for (int i = 0; i < int'(LS); i++) begin
            s += int'(m[i]);
            r[i*PW +: PW] = PW'(s);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] make_line(input logic [LS-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(LS); i++) r[i*WW +: WW] = m[i] ? WW'($urandom_range(1, 255)) : '0;
        return r;
    endfunction

    // Monitor: scoreboard outputs, hold-stability under backpressure, feed the model.
    initial begin
        logic          hold_prev;
        logic [DW-1:0] line_prev;
        logic [CW-1:0] cnt_prev;
        logic          last_prev;
        exp_t          e;
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wq.delete();
                eq.delete();
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", DW'(out_valid), DW'(1));
                    check("hold_line",  out_line, line_prev);
                    check("hold_count", DW'(out_count), DW'(cnt_prev));
                    check("hold_last",  DW'(out_last), DW'(last_prev));
                end
                if (out_valid && out_ready) begin
                    if (eq.size() == 0) begin
                        check("spurious_out", DW'(out_valid), DW'(0));
                    end else begin
                        e = eq.pop_front();
                        check("out_line",  out_line, e.line);
                        check("out_count", DW'(out_count), DW'(e.count));
                        check("out_last",  DW'(out_last), DW'(e.last));
                    end
                end
                if (in_valid && in_ready) model_accept(in_line, in_mask, in_last);
                hold_prev = out_valid && !out_ready;
                line_prev = out_line;
                cnt_prev  = out_count;
                last_prev = out_last;
            end
        end
    end

    initial begin
        rdy_rand = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] line, input logic [LS-1:0] mask, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_line  = line;
        in_mask  = mask;
        in_psum  = psum_of(mask);
        in_last  = last;
        assert (in_psum[(LS-1)*PW +: PW] == PW'($countones(mask)));
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) begin
                check("in_timeout", DW'(in_ready), DW'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((eq.size() != 0 || out_valid) && k < 500) begin
            tick(1);
            k++;
        end
        check("drain_pending", DW'(eq.size()), DW'(0));
    endtask

    logic [DW-1:0] line_v;
    logic [LS-1:0] mask_v;
    logic          bp_done;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_line  = '0;
        in_mask  = '0;
        in_psum  = '0;
        in_last  = 1'b0;
        rdy_dir  = 1'b1;
        rand_rdy = 1'b0;
        bp_done  = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_line",  out_line, '0);
        check("rst_out_count", DW'(out_count), DW'(0));
        check("rst_out_last",  DW'(out_last), DW'(0));
        check("rst_in_ready",  DW'(in_ready), DW'(1));

        // Full line of words 1..32; output two edges after acceptance.
        for (int i = 0; i < int'(LS); i++) line_v[i*WW +: WW] = WW'(i + 1);
        in_valid = 1'b1;
        in_line  = line_v;
        in_mask  = '1;
        in_psum  = psum_of('1);
        in_last  = 1'b0;
        tick(1);
        in_valid = 1'b0;
        check("lat_edge1_valid", DW'(out_valid), DW'(0));
        tick(1);
        check("lat_edge2_valid", DW'(out_valid), DW'(1));
        check("full_count", DW'(out_count), DW'(LS));
        check("full_last",  DW'(out_last), DW'(0));
        check("full_line",  out_line, line_v);

        // Two half lines concatenate into one packed line.
        line_v = '0;
        for (int i = 0; i < 16; i++) line_v[i*WW +: WW] = WW'(8'hA0 + i);
        send(line_v, 32'h0000FFFF, 1'b0);
        tick(3);
        check("half_no_out", DW'(out_valid), DW'(0));
        line_v = '0;
        for (int i = 0; i < 16; i++) line_v[i*WW +: WW] = WW'(8'hB0 + i);
        send(line_v, 32'h0000FFFF, 1'b0);
        tick(1);
        check("half_pair_valid", DW'(out_valid), DW'(1));
        check("half_pair_count", DW'(out_count), DW'(LS));

        // Single kept word on a last line.
        line_v = '0;
        line_v[WW-1:0] = 8'hAA;
        send(line_v, 32'h00000001, 1'b1);
        tick(1);
        check("single_count", DW'(out_count), DW'(1));
        check("single_last",  DW'(out_last), DW'(1));
        check("single_line",  out_line, DW'(8'hAA));

        // F=20 then a last line with 20 kept words: full line, FLUSH, remainder of 8.
        send(make_line(32'h000FFFFF), 32'h000FFFFF, 1'b0);
        send(make_line(32'hFFFFF000), 32'hFFFFF000, 1'b1);
        rdy_dir = 1'b0;
        send(make_line(32'h0000001F), 32'h0000001F, 1'b0);
        check("flush_in_ready",  DW'(in_ready), DW'(0));
        check("flush_full_cnt",  DW'(out_count), DW'(LS));
        check("flush_full_last", DW'(out_last), DW'(0));
        tick(2);
        check("flush_in_ready_hold", DW'(in_ready), DW'(0));
        rdy_dir = 1'b1;
        tick(1);
        check("flush_rem_cnt",  DW'(out_count), DW'(8));
        check("flush_rem_last", DW'(out_last), DW'(1));
        check("flush_exit_in_ready", DW'(in_ready), DW'(1));
        send(make_line(32'hF0F0F0F0), 32'hF0F0F0F0, 1'b1);
        drain();

        // Backpressure: out_ready low for 5 cycles with input held valid.
        rdy_dir = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(make_line('1), '1, (k == 3));
                bp_done = 1'b1;
            end
        join_none
        tick(2);
        check("bp_in_ready_drop", DW'(in_ready), DW'(0));
        tick(3);
        check("bp_in_ready_low", DW'(in_ready), DW'(0));
        check("bp_out_valid",    DW'(out_valid), DW'(1));
        rdy_dir = 1'b1;
        for (int k = 0; k < 200 && !bp_done; k++) tick(1);
        check("bp_done", DW'(bp_done), DW'(1));
        drain();

        // Reset with F=10 and a held output; nothing from before reset may reappear.
        send(make_line(32'h003FFFFF), 32'h003FFFFF, 1'b0);
        send(make_line(32'h000FFFFF), 32'h000FFFFF, 1'b0);
        rdy_dir = 1'b0;
        tick(1);
        check("prerst_out_valid", DW'(out_valid), DW'(1));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_out_valid", DW'(out_valid), DW'(0));
        check("midrst_out_line",  out_line, '0);
        check("midrst_out_count", DW'(out_count), DW'(0));
        check("midrst_out_last",  DW'(out_last), DW'(0));
        check("midrst_in_ready",  DW'(in_ready), DW'(1));
        rdy_dir = 1'b1;
        send(make_line(32'h00000007), 32'h00000007, 1'b1);
        tick(1);
        check("postrst_count", DW'(out_count), DW'(3));
        drain();

        // Randomized tiles with random downstream readiness.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int nl;
            nl = $urandom_range(1, 6);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(0, 5))
                    0:       mask_v = '0;
                    1:       mask_v = '1;
                    2:       mask_v = LS'($urandom) & LS'($urandom);
                    default: mask_v = LS'($urandom);
                endcase
                send(make_line(mask_v), mask_v, (l == nl - 1));
                tick($urandom_range(0, 2) == 0 ? 1 : 0);
            end
        end
        rand_rdy = 1'b0;
        rdy_dir  = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zvc_line_packer.md
# zvc_line_packer

Stage directly downstream of the 32-lane Ladner-Fischer prefix adder in the zero-value compressor (ZVC) path. Consumes one LIFM line, its nonzero bitmask and the adder's inclusive prefix sums. Scatters the nonzero words into a dense run, then concatenates runs from consecutive lines into full packed output lines. Handles valid/ready backpressure and end-of-tile flush.

## Interface
Parameters:
- WORD_WIDTH, 8, bits per LIFM word
- LINE_SIZE, 32, words per line; must match the prefix adder lane count
- PSUM_WIDTH, 32, width of one prefix-sum entry as produced by the adder
- CNT_WIDTH, 6, width of word counts (holds 0..LINE_SIZE)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input line valid
- in_ready  out  1  input line accepted when in_valid && in_ready
- in_line  in  LINE_SIZE*WORD_WIDTH  word i at [i*WORD_WIDTH +: WORD_WIDTH]
- in_mask  in  LINE_SIZE  bit i = 1 when word i is kept (nonzero)
- in_psum  in  LINE_SIZE*PSUM_WIDTH  entry i = popcount(in_mask[0..i]), at [i*PSUM_WIDTH +: PSUM_WIDTH]
- in_last  in  1  final line of the tile; forces flush
- out_valid  out  1  packed line valid
- out_ready  in  1  downstream accept
- out_line  out  LINE_SIZE*WORD_WIDTH  packed words, word 0 = oldest
- out_count  out  CNT_WIDTH  valid words in out_line (LINE_SIZE except on flush)
- out_last  out  1  final packed line of the tile

## Operation
- Stage S1 (scatter): for each i with in_mask[i]=1, word i goes to slot in_psum[i]-1. Only the low CNT_WIDTH bits of each psum entry are used. Unfilled slots are 0. S1 registers the compact line, c = psum[LINE_SIZE-1], and last.
- Stage S2 (accumulate): buffer acc holds F words, 0 ≤ F < LINE_SIZE between lines. An S1 line is appended at acc slot F; T = F + c (0..2*LINE_SIZE-1).
  - T < LINE_SIZE, !last: F ← T, no output.
  - T ≥ LINE_SIZE: emit first LINE_SIZE words, out_count = LINE_SIZE. Remaining T-LINE_SIZE words shift to slot 0 and F ← T-LINE_SIZE.
  - last && T ≤ LINE_SIZE: emit acc with out_count = T, out_last = 1, unused slots 0, F ← 0. T = 0 emits an all-zero line with count 0 and out_last = 1.
  - last && T > LINE_SIZE: emit full line (out_last = 0), enter FLUSH, then emit the remainder (count T-LINE_SIZE, out_last = 1), return to ACCUM, F ← 0.
- FSM states: ACCUM (reset state) and FLUSH. FLUSH lasts until the remainder line is accepted. S1 does not advance while in FLUSH.
- Output register: holds out_* stable while out_valid && !out_ready. It is loaded only when empty or being drained in the same cycle.
- S2 advance = s1_valid && (!out_valid || out_ready) && state == ACCUM. S1 is not required to produce output to advance.
- in_ready = !s1_valid || s2_advance.
- The block does not check psum/mask consistency. The bench asserts it.

## Timing
- Reset values: out_valid = 0, out_line = 0, out_count = 0, out_last = 0, F = 0, state = ACCUM, s1_valid = 0. in_ready = 1 in the first cycle after reset.
- Latency: line accepted at edge N; S1 valid after N+1. If it completes a line with no backpressure, out_valid is high after edge N+2.
- Throughput: one input line per cycle with out_ready held high, except one bubble per last-line FLUSH.
- Simultaneous drain and load of the output register in one cycle is allowed, with no bubble.
- Reset mid-operation: acc, S1 and the output register are discarded; no partial line is emitted afterwards.
- Back-to-back tiles: the first line of the next tile may enter S1 while FLUSH is draining. It does not enter S2 until FLUSH exits.

## Structure
- Shared package zvc_pkg: WORD_WIDTH, LINE_SIZE, CNT_WIDTH, PSUM_WIDTH defaults, and the FSM state enum (ACCUM, FLUSH). The ZVC top and the prefix adder wrapper use the same package.
- Sub-module zvc_line_scatter: combinational, takes in_line/in_mask/in_psum and produces the compact line and count. It is instantiated in S1 and tested on its own.

## Test plan
- All-ones mask, words 1..32, out_ready = 1: out_line = 1..32, count 32, out_last = 0, out_valid 2 cycles after accept.
- Two lines, each with mask 0x0000FFFF (A0..A15, then B0..B15): no output after line 1; after line 2, out_line = A0..A15,B0..B15, count 32.
- Single line, mask 0x00000001, word0 = 0xAA, in_last = 1: count 1, out_last = 1, word0 = 0xAA, words 1..31 = 0.
- F = 20, then a last line with 20 kept words: full line (out_last = 0), then remainder count 8 with out_last = 1 on the next accepted cycle. in_ready stays low while FLUSH holds S1.
- out_ready low for 5 cycles with in_valid held high: in_ready drops within 2 cycles and out_* stay stable. After release, the output order matches the golden model with no loss or duplication.
- Reset asserted with F = 10 and out_valid = 1: all outputs reach reset values next cycle. The next tile's output contains no pre-reset words.
